// File: rtl/cheese_spawner.sv
// Cheese position/visibility owner: hides the cheese when taken, waits out a respawn
// delay, then places it at a pseudo-random legal spot away from Jerry.
module cheese_spawner #(
  parameter int unsigned X_MIN         = 32,
  parameter int unsigned X_MAX         = 960,
  parameter int unsigned Y_MIN         = 64,
  parameter int unsigned Y_MAX         = 700,
  parameter int unsigned MIN_DIST      = 100,
  parameter int unsigned RESPAWN_DELAY = 65000,
  parameter int unsigned MAX_TRIES     = 64,
  parameter int unsigned FALLBACK_X    = 512,
  parameter int unsigned FALLBACK_Y    = 384,
  parameter logic [19:0] LFSR_SEED     = 20'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_i,
  input  logic        is_cheese_taken_i,
  input  logic [11:0] jerrypos_x_i,
  input  logic [11:0] jerrypos_y_i,
  output logic [11:0] cheesepos_x_o,
  output logic [11:0] cheesepos_y_o,
  output logic        cheese_visible_o,
  output logic [7:0]  respawn_ctr_o
);

  // state  | meaning
  // PICK   | cheese hidden, testing one LFSR candidate per cycle
  // ACTIVE | cheese shown at a fixed position, waiting to be taken
  // WAIT   | cheese hidden, counting out the respawn delay
  typedef enum logic [1:0] {PICK, ACTIVE, WAIT} state_e;

  localparam int unsigned DW = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
  localparam int unsigned TW = $clog2(MAX_TRIES + 1);
  localparam logic [DW-1:0] DELAY_LAST = DW'(RESPAWN_DELAY - 1);
  localparam logic [TW-1:0] TRY_LAST   = TW'(MAX_TRIES - 1);
  localparam logic [12:0]   X_LO       = 13'(X_MIN);
  localparam logic [12:0]   X_HI       = 13'(X_MAX);
  localparam logic [12:0]   Y_LO       = 13'(Y_MIN);
  localparam logic [12:0]   Y_HI       = 13'(Y_MAX);
  localparam logic [12:0]   DIST       = 13'(MIN_DIST);
  localparam logic [11:0]   FB_X       = 12'(FALLBACK_X);
  localparam logic [11:0]   FB_Y       = 12'(FALLBACK_Y);

  state_e          state_q, state_d;
  logic [19:0]     lfsr_q, lfsr_d;
  logic [DW-1:0]   delay_q, delay_d;
  logic [TW-1:0]   try_q, try_d;
  logic [11:0]     pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic            visible_q, visible_d;
  logic [7:0]      ctr_q, ctr_d;

  logic [12:0] cx, cy, jx, jy, dx, dy;
  logic        in_window, far_enough, accept;

  assign lfsr_d = {lfsr_q[18:0], lfsr_q[19] ^ lfsr_q[16]};

  // Differences kept unsigned and one bit wider so nothing wraps.
  assign cx = {3'b000, lfsr_q[9:0]};
  assign cy = {3'b000, lfsr_q[19:10]};
  assign jx = {1'b0, jerrypos_x_i};
  assign jy = {1'b0, jerrypos_y_i};
  assign dx = (cx >= jx) ? (cx - jx) : (jx - cx);
  assign dy = (cy >= jy) ? (cy - jy) : (jy - cy);

  assign in_window  = (cx >= X_LO) && (cx <= X_HI) && (cy >= Y_LO) && (cy <= Y_HI);
  assign far_enough = (dx >= DIST) || (dy >= DIST);
  assign accept     = in_window && far_enough;

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    try_d     = try_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    visible_d = visible_q;
    ctr_d     = ctr_q;
    if (reset_i) begin
      state_d   = PICK;
      visible_d = 1'b0;
      ctr_d     = '0;
      delay_d   = '0;
      try_d     = '0;
    end else begin
      unique case (state_q)
        PICK: begin
          if (accept) begin
            pos_x_d   = cx[11:0];
            pos_y_d   = cy[11:0];
            visible_d = 1'b1;
            ctr_d     = ctr_q + 8'd1;
            try_d     = '0;
            state_d   = ACTIVE;
          end else if (try_q == TRY_LAST) begin
            pos_x_d   = FB_X;
            pos_y_d   = FB_Y;
            visible_d = 1'b1;
            ctr_d     = ctr_q + 8'd1;
            try_d     = '0;
            state_d   = ACTIVE;
          end else begin
            try_d = try_q + TW'(1);
          end
        end
        ACTIVE: begin
          if (is_cheese_taken_i) begin
            visible_d = 1'b0;
            delay_d   = '0;
            state_d   = WAIT;
          end
        end
        WAIT: begin
          if (delay_q == DELAY_LAST) begin
            delay_d = '0;
            state_d = PICK;
          end else begin
            delay_d = delay_q + DW'(1);
          end
        end
        default: state_d = PICK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PICK;
      lfsr_q    <= LFSR_SEED;
      delay_q   <= '0;
      try_q     <= '0;
      pos_x_q   <= FB_X;
      pos_y_q   <= FB_Y;
      visible_q <= 1'b0;
      ctr_q     <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      delay_q   <= delay_d;
      try_q     <= try_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      visible_q <= visible_d;
      ctr_q     <= ctr_d;
    end
  end

  assign cheesepos_x_o    = pos_x_q;
  assign cheesepos_y_o    = pos_y_q;
  assign cheese_visible_o = visible_q;
  assign respawn_ctr_o    = ctr_q;

endmodule

// File: tb/tb_cheese_spawner.sv
// Randomized bench for cheese_spawner: a look-ahead model predicts where and when each
// respawn lands; a second instance with an unsatisfiable distance exercises the fallback.
module tb_cheese_spawner;

  localparam int D       = 16;
  localparam int MT      = 64;
  localparam int MD      = 100;
  localparam int MD_FAR  = 2000;
  localparam int FBX     = 512;
  localparam int FBY     = 384;
  localparam logic [19:0] SEED = 20'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reset_i = 1'b0;
  logic        taken_i = 1'b0;
  logic        reset_far_i = 1'b0;
  logic        taken_far_i = 1'b0;
  logic [11:0] jx_i = 12'd0;
  logic [11:0] jy_i = 12'd0;
  logic [11:0] cx_o, cy_o, fx_o, fy_o;
  logic        vis_o, fvis_o;
  logic [7:0]  ctr_o, fctr_o;

  cheese_spawner #(.MIN_DIST(MD), .RESPAWN_DELAY(D), .MAX_TRIES(MT)) u_dut (
    .clk(clk), .rst(rst), .reset_i(reset_i), .is_cheese_taken_i(taken_i),
    .jerrypos_x_i(jx_i), .jerrypos_y_i(jy_i),
    .cheesepos_x_o(cx_o), .cheesepos_y_o(cy_o),
    .cheese_visible_o(vis_o), .respawn_ctr_o(ctr_o));

  cheese_spawner #(.MIN_DIST(MD_FAR), .RESPAWN_DELAY(D), .MAX_TRIES(MT)) u_far (
    .clk(clk), .rst(rst), .reset_i(reset_far_i), .is_cheese_taken_i(taken_far_i),
    .jerrypos_x_i(jx_i), .jerrypos_y_i(jy_i),
    .cheesepos_x_o(fx_o), .cheesepos_y_o(fy_o),
    .cheese_visible_o(fvis_o), .respawn_ctr_o(fctr_o));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit far_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] lfsr_step(input logic [19:0] l);
    return {l[18:0], l[19] ^ l[16]};
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit legal(input int x, input int y, input int jx, input int jy, input int md);
    return (x >= 32) && (x <= 960) && (y >= 64) && (y <= 700) &&
           ((absdiff(x, jx) >= md) || (absdiff(y, jy) >= md));
  endfunction

  // Given the LFSR value seen on the first PICK cycle, find how many cycles the
  // search takes and where the cheese ends up.
  task automatic predict(input logic [19:0] l0, input int jx, input int jy, input int md,
                         output int n, output int px, output int py);
    logic [19:0] l;
    l  = l0;
    n  = MT;
    px = FBX;
    py = FBY;
    for (int k = 0; k < MT; k++) begin
      if (legal(int'(l[9:0]), int'(l[19:10]), jx, jy, md)) begin
        n  = k + 1;
        px = int'(l[9:0]);
        py = int'(l[19:10]);
        break;
      end
      l = lfsr_step(l);
    end
  endtask

  logic [19:0] m_lfsr;
  int exp_ctr = 0;
  int cur_x = FBX;
  int cur_y = FBY;

  task automatic tick();
    @(posedge clk);
    #1;
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  task automatic do_pick(input bit stray);
    int n, px, py;
    predict(m_lfsr, int'(jx_i), int'(jy_i), MD, n, px, py);
    if (stray) taken_i = 1'b1;
    repeat (n - 1) tick();
    check("pick_hidden", int'(vis_o), 0);
    check("pick_pos_held_x", int'(cx_o), cur_x);
    check("pick_pos_held_y", int'(cy_o), cur_y);
    tick();
    taken_i = 1'b0;
    exp_ctr = (exp_ctr + 1) % 256;
    check("spawn_visible", int'(vis_o), 1);
    check("spawn_x", int'(cx_o), px);
    check("spawn_y", int'(cy_o), py);
    check("spawn_ctr", int'(ctr_o), exp_ctr);
    cur_x = px;
    cur_y = py;
  endtask

  task automatic do_take(input int stray_at, input int idle);
    repeat (idle) begin
      tick();
      check("active_visible", int'(vis_o), 1);
    end
    taken_i = 1'b1;
    tick();
    taken_i = 1'b0;
    check("taken_hidden", int'(vis_o), 0);
    check("taken_pos_x", int'(cx_o), cur_x);
    check("taken_pos_y", int'(cy_o), cur_y);
    for (int i = 0; i < D; i++) begin
      if (i == stray_at) taken_i = 1'b1;
      tick();
      taken_i = 1'b0;
    end
    check("wait_hidden", int'(vis_o), 0);
  endtask

  initial begin
    @(negedge rst);
    repeat (MT - 1) @(posedge clk);
    #1;
    check("far_pick_hidden", int'(fvis_o), 0);
    check("far_pick_ctr", int'(fctr_o), 0);
    @(posedge clk);
    #1;
    check("far_fallback_vis", int'(fvis_o), 1);
    check("far_fallback_x", int'(fx_o), FBX);
    check("far_fallback_y", int'(fy_o), FBY);
    check("far_fallback_ctr", int'(fctr_o), 1);
    far_done = 1'b1;
  end

  initial begin
    int r;
    m_lfsr = SEED;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_lfsr = SEED;
    check("rst_visible", int'(vis_o), 0);
    check("rst_ctr", int'(ctr_o), 0);
    check("rst_x", int'(cx_o), FBX);
    check("rst_y", int'(cy_o), FBY);

    do_pick(1'b0);
    check("first_in_window",
          int'((cx_o >= 12'd32) && (cx_o <= 12'd960) && (cy_o >= 12'd64) && (cy_o <= 12'd700)), 1);

    do_take(D + 5, 2);
    do_pick(1'b1);
    check("second_ctr", int'(ctr_o), 2);

    // Game reset in the middle of the respawn delay.
    taken_i = 1'b1;
    tick();
    taken_i = 1'b0;
    r = int'($urandom_range(3, D - 4));
    repeat (r) tick();
    reset_i = 1'b1;
    tick();
    check("greset_visible", int'(vis_o), 0);
    check("greset_ctr", int'(ctr_o), 0);
    check("greset_x", int'(cx_o), cur_x);
    check("greset_y", int'(cy_o), cur_y);
    repeat (int'($urandom_range(0, 2))) tick();
    reset_i = 1'b0;
    exp_ctr = 0;
    do_pick(1'b0);

    // Game reset together with a take pulse while ACTIVE: the reset wins.
    reset_i = 1'b1;
    taken_i = 1'b1;
    tick();
    reset_i = 1'b0;
    taken_i = 1'b0;
    check("greset_take_vis", int'(vis_o), 0);
    check("greset_take_ctr", int'(ctr_o), 0);
    exp_ctr = 0;
    do_pick(1'b0);

    for (int i = 0; i < 40; i++) begin
      jx_i = 12'($urandom_range(0, 1023));
      jy_i = 12'($urandom_range(0, 1023));
      do_take(int'($urandom_range(0, 2 * D)), int'($urandom_range(0, 3)));
      do_pick(1'($urandom_range(0, 1)));
    end

    jx_i = 12'd500;
    jy_i = 12'd400;
    for (int i = 0; i < 1000; i++) begin
      do_take(int'($urandom_range(0, 2 * D)), int'($urandom_range(0, 1)));
      do_pick(1'($urandom_range(0, 1)));
    end

    check("far_done", int'(far_done), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
